// File: rtl/dtw_pkg.sv
// Shared types and helpers for the DTW row scheduler and its cell datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtw_pkg;

  // Width of the cumulative-cost datapath. The scheduler's COST_W parameter must equal this.
  localparam int DTW_COST_W = 32;

  typedef logic [DTW_COST_W-1:0] cost_t;

  // All-ones doubles as "unreachable" and as the saturation ceiling.
  localparam cost_t COST_INF = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    FETCH_A,
    CELL,
    FINISH
  } state_t;

  // Unsigned add that clamps at COST_INF instead of wrapping.
  function automatic cost_t sat_add(input cost_t x, input cost_t y);
    logic [DTW_COST_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[DTW_COST_W] ? COST_INF : sum[DTW_COST_W-1:0];
  endfunction

endpackage

// File: rtl/dtw_cell.sv
// One DTW cell: |a-b| plus the smallest of the three neighbour costs, saturating at INF.
// Latency: purely combinational.
// Backpressure: none.
module dtw_cell
  import dtw_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  cost_t             up,
  input  cost_t             left,
  input  cost_t             diag,
  output cost_t             cost
);

  logic [DATA_W-1:0] diff;
  cost_t             diff_ext;
  cost_t             min_ul;
  cost_t             min_all;

  // Larger-minus-smaller keeps the difference unsigned; then pick the cheapest predecessor.
  always_comb begin
    diff     = (a >= b) ? (a - b) : (b - a);
    diff_ext = cost_t'(diff);
    min_ul   = (up < left) ? up : left;
    min_all  = (min_ul < diag) ? min_ul : diag;
    cost     = sat_add(diff_ext, min_all);
  end

endmodule

// File: rtl/dtw_row_scheduler.sv
// Runs a full DTW over A/B sample RAMs: caches B, walks rows one cell/cycle, reports D[la-1][lb-1].
// Latency: done (lb+1)+la*(lb+2)+1 cycles after start accept; 1 cycle for invalid lengths. DTW_BAND_EN adds cfg_band.
// Backpressure: none; memories answer in one fixed cycle and cfg_start is dropped while busy.
module dtw_row_scheduler
  import dtw_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COST_W  = DTW_COST_W,
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic [ADDR_W:0]   cfg_len_a,
  input  logic [ADDR_W:0]   cfg_len_b,
`ifdef DTW_BAND_EN
  input  logic [ADDR_W:0]   cfg_band,
`endif
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [COST_W-1:0] result
);

  typedef logic [ADDR_W:0] len_t;
  localparam len_t LEN_ONE = len_t'(1);
  localparam len_t LEN_MAX = len_t'(MAX_LEN);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  len_t              la_q, la_d;
  len_t              lb_q, lb_d;
  len_t              cnt_q, cnt_d;       // LOAD_B issue index, runs 0..lb
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic              fa_ph_q, fa_ph_d;   // 0: issue A read, 1: capture A data
  logic [DATA_W-1:0] a_val_q, a_val_d;
  cost_t             left_q, left_d;
  cost_t             diag_q, diag_d;
  logic              err_q, err_d;
  cost_t             result_q, result_d;
`ifdef DTW_BAND_EN
  len_t              band_q, band_d;
`endif

  logic [DATA_W-1:0] b_cache_q [MAX_LEN];
  cost_t             prev_row_q [MAX_LEN];

  logic              b_we;
  logic [ADDR_W-1:0] b_widx;
  logic              pr_we;
  logic              len_bad;
  logic              out_band;
  cost_t             up;
  cost_t             cell_cost;
  cost_t             cost_eff;

  // Row 0 has no row above; otherwise the previous row's value in this column.
  assign up = (i_q == '0) ? COST_INF : prev_row_q[j_q];

  dtw_cell #(
    .DATA_W(DATA_W)
  ) u_cell (
    .a    (a_val_q),
    .b    (b_cache_q[j_q]),
    .up   (up),
    .left (left_q),
    .diag (diag_q),
    .cost (cell_cost)
  );

`ifdef DTW_BAND_EN
  logic [ADDR_W-1:0] ij_dist;
  assign ij_dist  = (i_q >= j_q) ? (i_q - j_q) : (j_q - i_q);
  assign out_band = ({1'b0, ij_dist} > band_q);
`else
  assign out_band = 1'b0;
`endif

  // Cells outside the band still take their cycle but contribute INF downstream.
  assign cost_eff = out_band ? COST_INF : cell_cost;

  assign len_bad = (cfg_len_a == '0) || (cfg_len_b == '0) ||
                   (cfg_len_a > LEN_MAX) || (cfg_len_b > LEN_MAX);

  assign a_addr = i_q;
  assign err    = err_q;
  assign result = result_q;

  // Next-state, counters and strobes for the run sequencer.
  always_comb begin
    state_d  = state_q;
    la_d     = la_q;
    lb_d     = lb_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    fa_ph_d  = fa_ph_q;
    a_val_d  = a_val_q;
    left_d   = left_q;
    diag_d   = diag_q;
    err_d    = err_q;
    result_d = result_q;
`ifdef DTW_BAND_EN
    band_d   = band_q;
`endif
    a_rd_en  = 1'b0;
    b_rd_en  = 1'b0;
    b_addr   = '0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    b_we     = 1'b0;
    b_widx   = ADDR_W'(cnt_q - LEN_ONE);
    pr_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          busy    = 1'b1;
          la_d    = cfg_len_a;
          lb_d    = cfg_len_b;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          fa_ph_d = 1'b0;
          err_d   = 1'b0;
`ifdef DTW_BAND_EN
          band_d  = cfg_band;
`endif
          if (len_bad) begin
            err_d    = 1'b1;
            result_d = COST_INF;
            state_d  = FINISH;
          end else begin
            result_d = '0;
            state_d  = LOAD_B;
          end
        end
      end

      LOAD_B: begin
        // Reads are issued on cycles 0..lb-1 and land one cycle later, so capture trails issue by one.
        if (cnt_q < lb_q) begin
          b_rd_en = 1'b1;
          b_addr  = cnt_q[ADDR_W-1:0];
        end
        if (cnt_q != '0) begin
          b_we = 1'b1;
        end
        if (cnt_q == lb_q) begin
          cnt_d   = '0;
          i_d     = '0;
          fa_ph_d = 1'b0;
          state_d = FETCH_A;
        end else begin
          cnt_d = cnt_q + LEN_ONE;
        end
      end

      FETCH_A: begin
        if (!fa_ph_q) begin
          a_rd_en = 1'b1;
          fa_ph_d = 1'b1;
        end else begin
          a_val_d = a_data;
          j_d     = '0;
          left_d  = COST_INF;
          diag_d  = (i_q == '0) ? '0 : COST_INF;
          fa_ph_d = 1'b0;
          state_d = CELL;
        end
      end

      CELL: begin
        pr_we  = 1'b1;
        diag_d = up;
        left_d = cost_eff;
        if ({1'b0, j_q} == (lb_q - LEN_ONE)) begin
          if ({1'b0, i_q} == (la_q - LEN_ONE)) begin
            result_d = cost_eff;
            state_d  = FINISH;
          end else begin
            i_d     = i_q + IDX_ONE;
            state_d = FETCH_A;
          end
        end else begin
          j_d = j_q + IDX_ONE;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers; synchronous reset aborts any run in progress.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      la_q     <= '0;
      lb_q     <= '0;
      cnt_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      fa_ph_q  <= 1'b0;
      a_val_q  <= '0;
      left_q   <= '0;
      diag_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef DTW_BAND_EN
      band_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      la_q     <= la_d;
      lb_q     <= lb_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      j_q      <= j_d;
      fa_ph_q  <= fa_ph_d;
      a_val_q  <= a_val_d;
      left_q   <= left_d;
      diag_q   <= diag_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef DTW_BAND_EN
      band_q   <= band_d;
`endif
    end
  end

  // B cache and previous-row storage; contents are don't-care after reset.
  always_ff @(posedge ACLK) begin
    if (!ARESET && b_we) begin
      b_cache_q[b_widx] <= b_data;
    end
    if (!ARESET && pr_we) begin
      prev_row_q[j_q] <= cost_eff;
    end
  end

endmodule

// File: tb/tb_dtw_row_scheduler.sv
// Scoreboard bench for dtw_row_scheduler against a full-matrix DTW reference model.
// Latency: checks done timing, busy span, read counts and address order per run.
// Backpressure: none; memory model answers one cycle after each read strobe.
module tb_dtw_row_scheduler;

  localparam int DATA_W  = 32;
  localparam int COST_W  = 32;
  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;
  localparam logic [31:0] INF32 = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [ADDR_W:0]   cfg_len_a;
  logic [ADDR_W:0]   cfg_len_b;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [COST_W-1:0] result;

  logic [31:0] mem_a [MAX_LEN];
  logic [31:0] mem_b [MAX_LEN];

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          start;
    int          ra;
    int          rb;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;
  int   rd_a = 0;
  int   rd_b = 0;

  always #5 clk = ~clk;

  dtw_row_scheduler #(
    .DATA_W (DATA_W),
    .COST_W (COST_W),
    .MAX_LEN(MAX_LEN),
    .ADDR_W (ADDR_W)
  ) dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .cfg_start(cfg_start),
    .cfg_len_a(cfg_len_a),
    .cfg_len_b(cfg_len_b),
    .a_rd_en  (a_rd_en),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_rd_en  (b_rd_en),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_data <= mem_a[a_addr];
    if (b_rd_en) b_data <= mem_b[b_addr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full cost matrix computed directly from the recurrence.
  function automatic logic [31:0] dtw_ref(input int la, input int lb);
    longint d [MAX_LEN][MAX_LEN];
    longint inf;
    longint up, left, diag, m, ad, s;
    inf = 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < la; i++) begin
      for (int j = 0; j < lb; j++) begin
        up   = (i > 0) ? d[i-1][j] : inf;
        left = (j > 0) ? d[i][j-1] : inf;
        if (i == 0 && j == 0)    diag = 0;
        else if (i > 0 && j > 0) diag = d[i-1][j-1];
        else                     diag = inf;
        m = up;
        if (left < m) m = left;
        if (diag < m) m = diag;
        ad = (mem_a[i] > mem_b[j]) ? longint'(mem_a[i]) - longint'(mem_b[j])
                                   : longint'(mem_b[j]) - longint'(mem_a[i]);
        s = ad + m;
        d[i][j] = (s > inf) ? inf : s;
      end
    end
    return 32'(d[la-1][lb-1]);
  endfunction

  function automatic logic [31:0] rand_sample(input int mode);
    case (mode)
      0:       return 32'($urandom_range(0, 15));
      1:       return $urandom();
      default: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic fill(input int la, input int lb, input int mode);
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < la) mem_a[k] = rand_sample(mode);
      if (k < lb) mem_b[k] = rand_sample(mode);
    end
  endtask

  // Issue one start, queue its expectation, optionally poke cfg_start mid-run, wait for the monitor.
  task automatic run(input int la, input int lb, input int poke);
    exp_t e;
    int   n;
    bit   ok;
    ok = (la >= 1) && (la <= MAX_LEN) && (lb >= 1) && (lb <= MAX_LEN);
    @(posedge clk);
    #1;
    cfg_len_a = 7'(la);
    cfg_len_b = 7'(lb);
    cfg_start = 1'b1;
    e.start = cyc;
    e.err   = !ok;
    e.res   = ok ? dtw_ref(la, lb) : INF32;
    e.lat   = ok ? (lb + 1) + la * (lb + 2) + 1 : 1;
    e.ra    = ok ? la : 0;
    e.rb    = ok ? lb : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    n = 1;
    while (sb.size() != 0 && n < e.lat + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (poke > 0 && n == poke) begin
        cfg_len_a = '0;
        cfg_len_b = 7'd1;
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
    end
    cfg_start = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles for la=%0d lb=%0d", n, la, lb);
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
      rd_a     = 0;
      rd_b     = 0;
    end else begin
      if (busy) busy_cnt++;
      if (b_rd_en) begin
        check("b_addr_order", longint'(b_addr), longint'(rd_b));
        rd_b++;
      end
      if (a_rd_en) begin
        check("a_addr_order", longint'(a_addr), longint'(rd_a));
        if (sb.size() != 0) check("b_loaded_before_a", longint'(rd_b), longint'(sb[0].rb));
        rd_a++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result",  longint'(result), longint'(e.res));
          check("err",     longint'(err), longint'(e.err));
          check("latency", longint'(cyc - e.start), longint'(e.lat));
          check("busy_span", longint'(busy_cnt), longint'(e.lat + 1));
          check("a_reads", longint'(rd_a), longint'(e.ra));
          check("b_reads", longint'(rd_b), longint'(e.rb));
        end
        busy_cnt = 0;
        rd_a     = 0;
        rd_b     = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    longint'(busy), 0);
    check({tag, "_done"},    longint'(done), 0);
    check({tag, "_err"},     longint'(err), 0);
    check({tag, "_result"},  longint'(result), 0);
    check({tag, "_a_rd_en"}, longint'(a_rd_en), 0);
    check({tag, "_b_rd_en"}, longint'(b_rd_en), 0);
    check({tag, "_a_addr"},  longint'(a_addr), 0);
    check({tag, "_b_addr"},  longint'(b_addr), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int la;
    int lb;
    int mode;
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_len_a = '0;
    cfg_len_b = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single cell: |5-2| = 3.
    mem_a[0] = 32'd5;
    mem_b[0] = 32'd2;
    run(1, 1, 0);

    // Identical sequences, with a cfg_start poke mid-run that must be ignored.
    for (int k = 0; k < 3; k++) begin
      mem_a[k] = 32'(k + 1);
      mem_b[k] = 32'(k + 1);
    end
    run(3, 3, 8);

    // Hand-computed example: rows 1,3,6 / 2,3,6.
    mem_a[0] = 0; mem_a[1] = 0;
    mem_b[0] = 1; mem_b[1] = 2; mem_b[2] = 3;
    run(2, 3, 0);

    // Invalid lengths.
    run(0, 3, 0);
    run(3, MAX_LEN + 1, 0);

    // Saturation: every cell clamps at INF.
    mem_a[0] = INF32; mem_a[1] = INF32;
    mem_b[0] = 0;     mem_b[1] = 0;
    run(2, 2, 0);

    // Abort in CELL: 4x4 run, reset 9 cycles after accept.
    fill(4, 4, 0);
    @(posedge clk);
    #1;
    cfg_len_a = 7'd4;
    cfg_len_b = 7'd4;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    rst = 1'b0;

    // Fresh run after the abort.
    mem_a[0] = 0; mem_a[1] = 0;
    mem_b[0] = 1; mem_b[1] = 2; mem_b[2] = 3;
    run(2, 3, 0);

    // Randomized runs, occasionally with invalid lengths.
    for (int t = 0; t < 25; t++) begin
      la   = $urandom_range(1, 10);
      lb   = $urandom_range(1, 10);
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) la = 0;
      if ($urandom_range(0, 7) == 0) lb = $urandom_range(MAX_LEN + 1, MAX_LEN + 6);
      fill(la, lb, mode);
      run(la, lb, 0);
    end

    // Largest legal matrix.
    fill(MAX_LEN, MAX_LEN, 0);
    run(MAX_LEN, MAX_LEN, 0);
    fill(MAX_LEN, 1, 0);
    run(MAX_LEN, 1, 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
